// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, key map,
// default timing parameters and the row-priority helper.
package keypad_pkg;

    localparam int DEFAULT_TICK_COUNT     = 100_000;
    localparam int DEFAULT_DEBOUNCE_SCANS = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    // Hex code per key, indexed by {row, col}; entry 0 is row 0 / column 0 ("1").
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // Rows are active-low; when several are low the lowest index wins.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_keymap.sv
// Combinational lookup from (row index, column index) to the key's hex code.
module keypad_keymap
    import keypad_pkg::*;
(
    input  logic [1:0] row_idx,
    input  logic [1:0] col_idx,
    output logic [3:0] code
);

    assign code = KEY_MAP[{row_idx, col_idx}];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column per scan slot,
// debounces presses and releases, and reports the accepted key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int TICK_COUNT     = DEFAULT_TICK_COUNT,
    parameter int DEBOUNCE_SCANS = DEFAULT_DEBOUNCE_SCANS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int TW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_COUNT - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_SCANS - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_SCANS);

    logic [3:0]    row_meta_q, row_meta_d;
    logic [3:0]    row_sync_q, row_sync_d;
    logic [TW-1:0] tick_q, tick_d;
    state_t        state_q, state_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    cand_row_q, cand_row_d;
    logic [CW-1:0] deb_cnt_q, deb_cnt_d;
    logic [CW-1:0] rel_cnt_q, rel_cnt_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic       sample;
    logic       any_low;
    logic [1:0] low_row;
    logic [3:0] map_code;
    logic       accept;
    logic       release_done;

    assign sample  = (tick_q == TICK_LAST);
    assign any_low = ~&row_sync_q;
    assign low_row = lowest_low_row(row_sync_q);

    // Whenever a key is accepted the lowest low row equals the candidate row.
    keypad_keymap u_keymap (
        .row_idx(low_row),
        .col_idx(col_idx_q),
        .code   (map_code)
    );

    always_comb begin
        row_meta_d = row;
        row_sync_d = row_meta_q;
        tick_d     = sample ? '0 : tick_q + TW'(1);
        col        = ~(4'b0001 << col_idx_q);
    end

    always_comb begin
        state_d      = state_q;
        col_idx_d    = col_idx_q;
        cand_row_d   = cand_row_q;
        deb_cnt_d    = deb_cnt_q;
        rel_cnt_d    = rel_cnt_q;
        key_code_d   = key_code_q;
        key_valid_d  = 1'b0;
        key_held_d   = key_held_q;
        accept       = 1'b0;
        release_done = 1'b0;

        if (sample) begin
            unique case (state_q)
                SCAN: begin
                    if (!any_low) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        cand_row_d = low_row;
                        deb_cnt_d  = CW'(1);
                        if (DEBOUNCE_SCANS <= 1) accept  = 1'b1;
                        else                     state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (any_low && (low_row == cand_row_q)) begin
                        if (deb_cnt_q != CNT_MAX) deb_cnt_d = deb_cnt_q + CW'(1);
                        if (deb_cnt_q >= CNT_LAST) accept = 1'b1;
                    end else begin
                        deb_cnt_d = '0;
                        state_d   = SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                HELD: begin
                    if (row_sync_q[cand_row_q]) begin
                        rel_cnt_d = CW'(1);
                        if (DEBOUNCE_SCANS <= 1) release_done = 1'b1;
                        else                     state_d      = RELEASE;
                    end
                end
                RELEASE: begin
                    if (row_sync_q[cand_row_q]) begin
                        if (rel_cnt_q != CNT_MAX) rel_cnt_d = rel_cnt_q + CW'(1);
                        if (rel_cnt_q >= CNT_LAST) release_done = 1'b1;
                    end else begin
                        rel_cnt_d = '0;
                        state_d   = HELD;
                    end
                end
            endcase

            if (accept) begin
                state_d     = HELD;
                deb_cnt_d   = '0;
                key_code_d  = map_code;
                key_valid_d = 1'b1;
                key_held_d  = 1'b1;
            end
            if (release_done) begin
                state_d    = SCAN;
                rel_cnt_d  = '0;
                key_held_d = 1'b0;
                col_idx_d  = col_idx_q + 2'd1;
            end
        end
    end

    // Synchronizer flops reset to the idle (all rows released) level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            tick_q      <= '0;
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            cand_row_q  <= 2'd0;
            deb_cnt_q   <= '0;
            rel_cnt_q   <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            tick_q      <= tick_d;
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            cand_row_q  <= cand_row_d;
            deb_cnt_q   <= deb_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical keypad model drives the rows
// and a slot-level reference model predicts col, key_code, key_valid and key_held.
module tb_keypad_scanner;

    localparam int TC = 10;
    localparam int DS = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed_mask = '0;

    bit [3:0] key_table [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'h0, 4'hF, 4'hE, 4'hD};
    bit [3:0] col_pattern [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    int         m_tick, m_col, m_cand, m_run, m_rel;
    logic       m_held, m_valid;
    logic [3:0] m_code;
    bit         sampled;
    int         tests_run = 0;
    int         tests_failed = 0;
    int         pulses_seen = 0;
    int         pulses_expected = 0;

    keypad_scanner #(.TICK_COUNT(TC), .DEBOUNCE_SCANS(DS)) dut (
        .clock    (clock),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clock = ~clock;

    // A pressed key pulls its row low only while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed_mask[r*4+c] && (col[c] === 1'b0)) row[r] = 1'b0;
    end

    function automatic logic [15:0] keyBit(input int r, input int c);
        return 16'(1) << (r * 4 + c);
    endfunction

    task automatic modelReset();
        m_tick = 0; m_col = 0; m_cand = 0; m_run = 0; m_rel = 0;
        m_held = 1'b0; m_valid = 1'b0; m_code = 4'h0;
    endtask

    // One scan-slot decision, taken from the rows the keypad shows on the current column.
    task automatic modelSample();
        logic [3:0] seen;
        int low;
        seen = 4'hF;
        low  = -1;
        for (int r = 3; r >= 0; r--)
            if (pressed_mask[r*4+m_col]) begin seen[r] = 1'b0; low = r; end
        if (!m_held) begin
            if (low < 0 || (m_run > 0 && low != m_cand)) begin
                m_run = 0;
                m_col = (m_col + 1) % 4;
            end else begin
                if (m_run == 0) m_cand = low;
                m_run++;
                if (m_run >= DS) begin
                    m_held  = 1'b1;
                    m_run   = 0;
                    m_rel   = 0;
                    m_code  = key_table[m_cand*4+m_col];
                    m_valid = 1'b1;
                    pulses_expected++;
                end
            end
        end else if (seen[m_cand]) begin
            m_rel++;
            if (m_rel >= DS) begin
                m_held = 1'b0;
                m_rel  = 0;
                m_col  = (m_col + 1) % 4;
            end
        end else begin
            m_rel = 0;
        end
    endtask

    task automatic checkOutput();
        if (key_valid === 1'b1) pulses_seen++;
        tests_run++;
        assert (col === col_pattern[m_col]) else begin
            tests_failed++;
            $error("[TB] FAIL col observed=%b expected=%b t=%0t", col, col_pattern[m_col], $time);
        end
        tests_run++;
        assert (key_valid === m_valid) else begin
            tests_failed++;
            $error("[TB] FAIL key_valid observed=%b expected=%b t=%0t", key_valid, m_valid, $time);
        end
        tests_run++;
        assert (key_held === m_held) else begin
            tests_failed++;
            $error("[TB] FAIL key_held observed=%b expected=%b t=%0t", key_held, m_held, $time);
        end
        tests_run++;
        assert (key_code === m_code) else begin
            tests_failed++;
            $error("[TB] FAIL key_code observed=%h expected=%h t=%0t", key_code, m_code, $time);
        end
    endtask

    task automatic runCycle();
        @(posedge clock);
        m_valid = 1'b0;
        sampled = 1'b0;
        if (!reset) begin
            if (m_tick == TC - 1) begin
                m_tick  = 0;
                modelSample();
                sampled = 1'b1;
            end else begin
                m_tick++;
            end
        end
        @(negedge clock);
        checkOutput();
    endtask

    task automatic applyStimulus(input logic [15:0] mask, input int nslots);
        int guard;
        pressed_mask = mask;
        for (int s = 0; s < nslots; s++) begin
            guard = 0;
            do begin
                runCycle();
                guard++;
            end while (!sampled && guard < TC + 2);
        end
    endtask

    task automatic waitForCol(input int c);
        int guard;
        guard = 0;
        while (m_col != c && guard < 12) begin
            applyStimulus(16'h0000, 1);
            guard++;
        end
    endtask

    task automatic checkScenario(input string tag, input int exp_pulses, input logic [3:0] exp_code);
        tests_run++;
        assert (pulses_seen === exp_pulses) else begin
            tests_failed++;
            $error("[TB] FAIL %s pulses observed=%0d expected=%0d", tag, pulses_seen, exp_pulses);
        end
        tests_run++;
        assert (key_code === exp_code) else begin
            tests_failed++;
            $error("[TB] FAIL %s code observed=%h expected=%h", tag, key_code, exp_code);
        end
    endtask

    initial begin
        int pick;
        logic [15:0] mask;

        reset = 1'b1;
        modelReset();
        for (int i = 0; i < 3; i++) runCycle();
        reset = 1'b0;

        $display("[TB] idle column walk");
        applyStimulus(16'h0000, 10);
        checkScenario("idle", 0, 4'h0);

        $display("[TB] key 5 held");
        applyStimulus(keyBit(1, 1), 12);
        applyStimulus(16'h0000, 8);
        checkScenario("key5", 1, 4'h5);

        $display("[TB] key 9 with bounce");
        waitForCol(2);
        applyStimulus(keyBit(2, 2), 2);
        applyStimulus(16'h0000, 1);
        checkScenario("key9_bounce", 1, 4'h5);
        applyStimulus(keyBit(2, 2), 8);
        applyStimulus(16'h0000, 6);
        checkScenario("key9", 2, 4'h9);

        $display("[TB] rows 0 and 3 together on column 3");
        applyStimulus(keyBit(0, 3) | keyBit(3, 3), 12);
        applyStimulus(16'h0000, 8);
        checkScenario("rows03", 3, 4'hA);

        $display("[TB] release of D with glitch");
        applyStimulus(keyBit(3, 3), 10);
        applyStimulus(16'h0000, 1);
        applyStimulus(keyBit(3, 3), 1);
        applyStimulus(16'h0000, 3);
        tests_run++;
        assert (key_held === 1'b1) else begin
            tests_failed++;
            $error("[TB] FAIL glitch_held observed=%b expected=1", key_held);
        end
        applyStimulus(16'h0000, 1);
        tests_run++;
        assert (key_held === 1'b0 && col === 4'b1110) else begin
            tests_failed++;
            $error("[TB] FAIL release_resume observed=%b/%b expected=0/1110", key_held, col);
        end
        applyStimulus(16'h0000, 2);
        checkScenario("keyD", 4, 4'hD);

        $display("[TB] reset during debounce of C");
        waitForCol(3);
        applyStimulus(keyBit(2, 3), 2);
        for (int i = 0; i < 4; i++) runCycle();
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput();
        for (int i = 0; i < 3; i++) runCycle();
        pressed_mask = 16'h0000;
        reset = 1'b0;
        runCycle();
        tests_run++;
        assert (col === 4'b1110 && key_valid === 1'b0 && key_held === 1'b0) else begin
            tests_failed++;
            $error("[TB] FAIL post_reset observed=%b/%b/%b expected=1110/0/0", col, key_valid, key_held);
        end
        applyStimulus(16'h0000, 6);
        checkScenario("resetC", 4, 4'h0);

        $display("[TB] randomized presses");
        for (int i = 0; i < 40; i++) begin
            pick = $urandom_range(0, 9);
            if (pick < 3)      mask = 16'h0000;
            else if (pick < 9) mask = 16'(1) << $urandom_range(0, 15);
            else               mask = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            applyStimulus(mask, $urandom_range(1, 8));
        end
        applyStimulus(16'h0000, 10);
        checkScenario("random", pulses_expected, m_code);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter TICK_COUNT, default 100_000, clock cycles per scan slot (1 ms at 100 MHz).
REQ-002 Parameter DEBOUNCE_SCANS, default 4, consecutive matching samples required to accept a press or a release.
REQ-003 Port clock  input  1  100 MHz system clock; the only clock in the block.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port row  input  4  keypad row lines, active-low, externally pulled up, asynchronous to clock.
REQ-006 Port col  output  4  keypad column drive, active-low, exactly one bit low at any time.
REQ-007 Port key_code  output  4  hex value of the last accepted key.
REQ-008 Port key_valid  output  1  one-cycle pulse when a new key press is accepted.
REQ-009 Port key_held  output  1  high from acceptance of a press until acceptance of its release.

Function
REQ-010 Row inputs SHALL pass through a 2-flop synchronizer before any use; the raw row SHALL never reach logic directly.
REQ-011 A tick counter SHALL count 0..TICK_COUNT-1, wrap to 0, and assert sample for one cycle at count TICK_COUNT-1.
REQ-012 Rows SHALL be evaluated only on sample cycles; the column drive changes only on the cycle after sample.
REQ-013 col SHALL follow 1110 -> 1101 -> 1011 -> 0111 -> 1110 (column index 0..3) while in SCAN.
REQ-014 The key map (row,col) SHALL be: r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: 0 F E D.
REQ-015 If several rows are low on one sample, the lowest row index SHALL win.
REQ-016 The FSM SHALL have states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-017 SCAN: sample with no row low -> advance column; any row low -> latch candidate (row,col), debounce count = 1, go DEBOUNCE, hold column.
REQ-018 DEBOUNCE: same row low -> increment count; when count reaches DEBOUNCE_SCANS, load key_code, pulse key_valid, go HELD.
REQ-019 DEBOUNCE: different row or no row low -> discard candidate, no key_valid, return to SCAN at the next column.
REQ-020 HELD: key_held = 1, column held; on the first sample with the candidate row high, release count = 1 and go RELEASE.
REQ-021 RELEASE: row high -> increment release count; row low again -> return to HELD with count cleared; count reaching DEBOUNCE_SCANS -> key_held = 0, go SCAN at the next column.
REQ-022 key_valid SHALL be registered, assert exactly one cycle per accepted press, and coincide with the key_code update.
REQ-023 key_code SHALL retain its value until the next accepted press.
REQ-024 Debounce and release counters SHALL saturate and never wrap.
REQ-025 DEBOUNCE_SCANS = 1 SHALL accept on the first sample, which makes the transition SCAN -> HELD direct.

Reset
REQ-026 Reset SHALL force state SCAN, col = 1110, key_code = 0, key_valid = 0, key_held = 0, and clear the tick, debounce and release counters and the synchronizer flops.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL abort the operation with no key_valid pulse; scanning SHALL resume from column 0 after deassertion.

Structure
REQ-028 Package keypad_pkg SHALL hold the FSM state encoding, the key-map table, and the default TICK_COUNT and DEBOUNCE_SCANS values.
REQ-029 Sub-module keypad_keymap SHALL be combinational, mapping (row index, column index) to the 4-bit hex code.

Verification (TICK_COUNT = 10, DEBOUNCE_SCANS = 4)
REQ-030 Reset, rows all high, 100 cycles -> col walks 1110, 1101, 1011, 0111 every 10 cycles; key_valid never asserts.
REQ-031 Key "5" (row1 low whenever col = 1101) held 8 slots -> exactly one key_valid; key_code = 5; key_held rises with it.
REQ-032 Key "9" bounces (row2 low 2 samples, high 1, low 4) -> a single key_valid, raised after the final 4 consecutive samples; key_code = 9.
REQ-033 Rows 0 and 3 low together on column 3 -> key_code = A.
REQ-034 Release of "D" with a 1-sample glitch low during RELEASE -> key_held stays 1 until 4 consecutive high samples, then falls; scanning resumes at column 0.
REQ-035 Reset pulsed during DEBOUNCE of "C" -> no key_valid; outputs at reset values; col = 1110 on the next cycle.
